// File: rtl/uart_rx_if.sv
// Host-side byte interface of the UART receiver: received byte with valid/ready
// handshake plus the framing-error and overrun status pulses.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampling start-bit validation, centre sampling of data
// and stop bits, byte hand-off on valid/ready with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  output logic      busy,
  uart_rx_if.master host
);

  localparam int OS_DIV      = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W       = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int CNT_W       = $clog2(OVERSAMPLE);
  localparam int SYNC_STAGES = 2;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(OS_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_MAX  = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;

  logic [DIV_W-1:0] div_reg;
  logic             os_tick;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shreg_reg, shreg_next;

  logic       load_byte;
  logic       stop_bad;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic       frame_err_reg;
  logic       overrun_reg;

  // Two-flop synchronizer; flops reset high so reset never looks like a start bit.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b1;
          else       sync_reg[gi] <= rx;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b1;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // Free-running oversample divider, never re-phased by line activity.
  always_ff @(posedge clk) begin
    if (reset)        div_reg <= '0;
    else if (os_tick) div_reg <= '0;
    else              div_reg <= div_reg + 1'b1;
  end

  assign os_tick = (div_reg == DIV_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shreg_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shreg_reg <= shreg_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shreg_next = shreg_reg;
    if (os_tick) begin
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_next = START;
            cnt_next   = '0;
          end
        end
        START: begin
          if (cnt_reg == HALF_MAX) begin
            if (!rx_s) begin
              state_next = DATA;
              cnt_next   = '0;
              idx_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == BIT_MAX) begin
            shreg_next = {rx_s, shreg_reg[7:1]};
            cnt_next   = '0;
            if (idx_reg == 3'd7) state_next = STOP;
            else                 idx_next   = idx_reg + 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (cnt_reg == BIT_MAX) begin
            state_next = rx_s ? IDLE : WAIT_HIGH;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must return high before a new start bit counts.
          if (rx_s) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    load_byte = 1'b0;
    stop_bad  = 1'b0;
    if (os_tick && (state_reg == STOP) && (cnt_reg == BIT_MAX)) begin
      load_byte = rx_s;
      stop_bad  = !rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= stop_bad;
      overrun_reg   <= load_byte && rx_valid_reg && !host.rx_ready;
      if (load_byte) begin
        rx_data_reg  <= shreg_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && host.rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign host.rx_data   = rx_data_reg;
  assign host.rx_valid  = rx_valid_reg;
  assign host.frame_err = frame_err_reg;
  assign host.overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 160 clk per bit (OS_DIV=10, 16x oversampling),
// frames driven on the falling clock edge and outputs checked there too.
module tb_uart_rx;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD_RATE  = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLK    = 160;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic busy;

  uart_rx_if host_if ();

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .busy (busy),
    .host (host_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int   valid_rises = 0;
  int   ferr_pulses = 0;
  int   ovr_pulses  = 0;
  logic prev_valid  = 1'b0;

  // Event counters; a pulse wider than one clk is counted more than once.
  always @(negedge clk) begin
    if (host_if.rx_valid === 1'b1 && prev_valid !== 1'b1) valid_rises++;
    if (host_if.frame_err === 1'b1) ferr_pulses++;
    if (host_if.overrun === 1'b1) ovr_pulses++;
    prev_valid = host_if.rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic ack_first);
    rx = 1'b0;
    if (ack_first) begin
      host_if.rx_ready = 1'b1;
      @(negedge clk);
      host_if.rx_ready = 1'b0;
      repeat (BIT_CLK - 1) @(negedge clk);
    end else begin
      repeat (BIT_CLK) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLK);
    hold(stop_bit, BIT_CLK);
  endtask

  task automatic accept();
    host_if.rx_ready = 1'b1;
    @(negedge clk);
    host_if.rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] partial;
    int         n;

    reset = 1'b1;
    rx = 1'b1;
    host_if.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_data",  host_if.rx_data,   32'h00);
    check("reset_valid", host_if.rx_valid,  32'h0);
    check("reset_ferr",  host_if.frame_err, 32'h0);
    check("reset_ovr",   host_if.overrun,   32'h0);
    check("reset_busy",  busy,              32'h0);

    // Single byte, consumer not ready
    send_byte(8'hA5, 1'b1, 1'b0);
    check("a5_valid", host_if.rx_valid, 32'h1);
    check("a5_data",  host_if.rx_data,  32'hA5);
    check("a5_ferr",  ferr_pulses,      32'd0);
    check("a5_ovr",   ovr_pulses,       32'd0);

    accept();
    check("hs_valid_low", host_if.rx_valid, 32'h0);
    check("hs_data_hold", host_if.rx_data,  32'hA5);

    // Back-to-back 0x00 / 0xFF; 0x00 is consumed during the 0xFF start bit
    send_byte(8'h00, 1'b1, 1'b0);
    check("b2b0_data",  host_if.rx_data,  32'h00);
    check("b2b0_valid", host_if.rx_valid, 32'h1);
    send_byte(8'hFF, 1'b1, 1'b1);
    check("b2b1_data",  host_if.rx_data,  32'hFF);
    check("b2b_rises",  valid_rises,      32'd3);
    check("b2b_ovr",    ovr_pulses,       32'd0);
    accept();
    check("b2b1_consumed", host_if.rx_valid, 32'h0);

    // Overrun
    send_byte(8'h3C, 1'b1, 1'b0);
    check("ovr_first_data", host_if.rx_data, 32'h3C);
    send_byte(8'hC3, 1'b1, 1'b0);
    check("ovr_count", ovr_pulses,       32'd1);
    check("ovr_data",  host_if.rx_data,  32'hC3);
    check("ovr_valid", host_if.rx_valid, 32'h1);
    check("ovr_rises", valid_rises,      32'd4);
    accept();

    // Glitch shorter than half a bit
    hold(1'b0, 40);
    check("glitch_busy", busy, 32'h1);
    rx = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("glitch_busy_fall", busy,             32'h0);
    check("glitch_no_valid",  valid_rises,      32'd4);
    check("glitch_valid_low", host_if.rx_valid, 32'h0);
    check("glitch_ferr",      ferr_pulses,      32'd0);

    // Framing error followed by a break
    send_byte(8'h55, 1'b0, 1'b0);
    hold(1'b0, 2000);
    check("brk_ferr",     ferr_pulses, 32'd1);
    check("brk_busy",     busy,        32'h1);
    hold(1'b1, 320);
    check("brk_idle",     busy,        32'h0);
    check("brk_ferr_one", ferr_pulses, 32'd1);
    check("brk_no_valid", valid_rises, 32'd4);
    send_byte(8'h81, 1'b1, 1'b0);
    check("brk_next_data",  host_if.rx_data,  32'h81);
    check("brk_next_valid", host_if.rx_valid, 32'h1);
    accept();

    // Reset in the middle of data bit 3 of 0x96
    partial = 8'h96;
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) hold(partial[i], BIT_CLK);
    hold(partial[3], BIT_CLK / 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    check("rst_data",  host_if.rx_data,  32'h00);
    check("rst_valid", host_if.rx_valid, 32'h0);
    check("rst_busy",  busy,             32'h0);
    hold(1'b1, 1600);
    check("rst_no_valid", valid_rises, 32'd5);
    check("rst_no_ferr",  ferr_pulses, 32'd1);
    check("rst_idle",     busy,        32'h0);
    send_byte(8'h96, 1'b1, 1'b0);
    check("rst_next_data",  host_if.rx_data,  32'h96);
    check("rst_next_valid", host_if.rx_valid, 32'h1);
    check("rst_next_rises", valid_rises,      32'd6);
    check("rst_next_ovr",   ovr_pulses,       32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART block: the receive end of the 8N1 link whose transmit side is paced by the baud tick generator. It oversamples the asynchronous `rx` line with an internal tick divider, detects and validates start bits, samples each data bit at its centre and presents received bytes on a valid/ready interface. It also flags framing errors and overruns to the host logic.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line bit rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit. Must be even and ≥ 4.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  8  last received byte.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: an unconsumed byte was overwritten.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops (reset value 1) to form `rx_s`. All decisions use `rx_s`.
- **Tick divider:**
  - `OS_DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE)` (integer division). Counter width is `$clog2(OS_DIV)`, minimum 1.
  - Counter runs 0..OS_DIV-1 and wraps. `os_tick` is high for the one cycle the counter equals OS_DIV-1.
  - The counter is free-running and never restarted by frame activity.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. `cnt` counts ticks within a state; `idx` is the 0..7 bit index. Every transition occurs only on `os_tick`.
- **IDLE:** if `rx_s==0` → START, `cnt<=0`.
- **START:** `cnt++`. When `cnt==OVERSAMPLE/2-1`:
  - `rx_s==0` → DATA, `cnt<=0`, `idx<=0`.
  - `rx_s==1` → IDLE (glitch rejected; no output activity).
- **DATA:** `cnt++`. When `cnt==OVERSAMPLE-1`:
  - shift `rx_s` in LSB-first (`shreg <= {rx_s, shreg[7:1]}`), `cnt<=0`.
  - if `idx==7` → STOP, else `idx++`.
- **STOP:** `cnt++`. When `cnt==OVERSAMPLE-1`:
  - `rx_s==1` → load byte, IDLE.
  - `rx_s==0` → `frame_err` pulse, no load, WAIT_HIGH.
- **WAIT_HIGH:** stays until `rx_s==1` on a tick → IDLE. This prevents a break condition from being read as back-to-back start bits.
- **Byte load:** `rx_data<=shreg_final`, `rx_valid<=1`.
  - If `rx_valid` was already 1 and not accepted in the same cycle, pulse `overrun`. The new byte replaces the old one.
  - If the load and acceptance happen in the same cycle, `rx_valid` stays 1 and there is no overrun.
- **Acceptance:** `rx_valid & rx_ready` with no load in the same cycle → `rx_valid<=0`. `rx_data` holds its value.

## Timing
- **Reset values:** `rx_data=0`, `rx_valid=0`, `frame_err=0`, `overrun=0`, `busy=0`. FSM=IDLE, divider=0, `cnt=0`, `idx=0`, `shreg=0`, synchronizer flops=1.
- Reset asserted mid-frame aborts the frame in the next cycle. No `rx_valid`, `frame_err` or `overrun` is produced for the aborted frame.
- Start-edge detection latency: 2 clk (synchronizer) plus up to 1 tick period.
- Start validation occurs `OVERSAMPLE/2` ticks after detection. Each data bit and the stop bit are sampled every `OVERSAMPLE` ticks thereafter, i.e. near each bit centre.
- `rx_valid`, `frame_err` and `overrun` change on the clk edge following the stop-sample `os_tick` cycle.
- `frame_err` and `overrun` are exactly 1 clk wide.
- `busy` rises the cycle after leaving IDLE and falls the cycle after entering IDLE.
- A new frame may start on the first tick after return to IDLE. Back-to-back frames with no extra idle time are received without loss.

## Test plan
All scenarios use `CLK_FREQ=1_600_000`, `BAUD_RATE=10_000`, `OVERSAMPLE=16`, giving `OS_DIV=10` and 160 clk/bit.

- **Single byte:** drive 0xA5 (8N1, 160 clk/bit), `rx_ready=0` → `rx_valid=1` and `rx_data=0xA5` within 1 bit time after the stop-bit start. `frame_err=0`, `overrun=0`.
- **Handshake:** after `rx_valid`, assert `rx_ready` for 1 cycle → `rx_valid=0` next cycle and `rx_data` stays 0xA5. Then send 0x00 and 0xFF back-to-back → two loads, `rx_data` 0x00 then 0xFF, each consumed.
- **Overrun:** send 0x3C then 0xC3 with `rx_ready=0` → one `overrun` pulse at the second load, `rx_data=0xC3`, `rx_valid=1`.
- **Glitch:** pulse `rx` low for 40 clk, then hold high → FSM returns to IDLE. `busy` falls within 8 ticks and there is no `rx_valid`.
- **Framing/break:** send 0x55 with the stop bit low, then hold `rx` low for 2000 clk, then high → exactly one `frame_err` pulse and no `rx_valid`. FSM stays in WAIT_HIGH until `rx` rises; a following 0x81 is received correctly.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 3 of 0x96 → all outputs return to reset values, no output for that frame, and the next 0x96 is received correctly.
